// File: rtl/line_cmd_sequencer_if.sv
// Push-side and drawer-side signal bundle for line_cmd_sequencer.
// master = controller/host side, slave = the sequencer itself.
`timescale 1ns/1ps
interface line_cmd_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          i_push;
  logic [8:0]    i_x0;
  logic [7:0]    i_y0;
  logic [8:0]    i_x1;
  logic [7:0]    i_y1;
  logic [2:0]    i_colour;
  logic          i_flush;
  logic          i_clear_status;
  logic          i_done;
  logic          o_go;
  logic [8:0]    o_X0;
  logic [7:0]    o_Y0;
  logic [8:0]    o_X1;
  logic [7:0]    o_Y1;
  logic [2:0]    o_colour;
  logic          o_full;
  logic          o_empty;
  logic [CW-1:0] o_count;
  logic          o_busy;
  logic [15:0]   o_lines_done;
  logic          o_overflow;
  logic          o_timeout;
  logic [1:0]    dbg_state;

  modport master (
    output i_push, i_x0, i_y0, i_x1, i_y1, i_colour,
    output i_flush, i_clear_status, i_done,
    input  o_go, o_X0, o_Y0, o_X1, o_Y1, o_colour,
    input  o_full, o_empty, o_count, o_busy,
    input  o_lines_done, o_overflow, o_timeout, dbg_state
  );

  modport slave (
    input  i_push, i_x0, i_y0, i_x1, i_y1, i_colour,
    input  i_flush, i_clear_status, i_done,
    output o_go, o_X0, o_Y0, o_X1, o_Y1, o_colour,
    output o_full, o_empty, o_count, o_busy,
    output o_lines_done, o_overflow, o_timeout, dbg_state
  );
endinterface

// File: rtl/line_cmd_sequencer.sv
// Queues line-draw commands and issues them one at a time to the line drawer.
// Optional draw watchdog is enabled by defining LINE_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module line_cmd_sequencer #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clock,
  input  logic               i_reset_n,
  line_cmd_sequencer_if.slave bus
);
  // Handshakes: i_push is a one-cycle valid with no ready; o_full is advisory
  // and a push while full is dropped and flagged in o_overflow. Towards the
  // drawer, o_go is the request and stays high until i_done is sampled (or the
  // watchdog fires); i_done is only honoured while o_go is high.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 37;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("line_cmd_sequencer: DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic          push_ok, push_drop, pop, complete, tmo_hit;
  logic [8:0]    x0_q, x1_q;
  logic [7:0]    y0_q, y1_q;
  logic [2:0]    colour_q;
  logic [15:0]   lines_q;
  logic          overflow_q;

  // A flush in the same cycle swallows the push without flagging overflow.
  assign push_ok   = bus.i_push && !bus.i_flush && (count != FULL_CNT);
  assign push_drop = bus.i_push && !bus.i_flush && (count == FULL_CNT);
  assign head      = mem[rd_ptr];

`ifdef LINE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] draw_cnt;
  logic          timeout_q;

  assign tmo_hit = (state == S_DRAW) && (draw_cnt == TMO_LAST);

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      draw_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (pop)
        draw_cnt <= '0;
      else if (state == S_DRAW)
        draw_cnt <= draw_cnt + TW'(1);
      // A coincident i_done is a completion, not a timeout.
      timeout_q <= (tmo_hit && !bus.i_done) || (timeout_q && !bus.i_clear_status);
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  assign tmo_hit       = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    complete   = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0 && !bus.i_flush) begin
          pop        = 1'b1;
          state_next = S_DRAW;
        end
      end
      S_DRAW: begin
        if (bus.i_done) begin
          complete   = 1'b1;
          state_next = S_GAP;
        end else if (tmo_hit) begin
          state_next = S_GAP;
        end
      end
      S_GAP:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_ok)
      mem[wr_ptr] <= {bus.i_x0, bus.i_y0, bus.i_x1, bus.i_y1, bus.i_colour};
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      colour_q   <= '0;
      lines_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state <= state_next;
      if (bus.i_flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push_ok) - CW'(pop);
      end
      if (pop)
        {x0_q, y0_q, x1_q, y1_q, colour_q} <= head;
      // Set events beat a simultaneous clear.
      if (bus.i_clear_status)
        lines_q <= {15'd0, complete};
      else if (complete)
        lines_q <= lines_q + 16'd1;
      overflow_q <= push_drop || (overflow_q && !bus.i_clear_status);
    end
  end

  assign bus.o_go         = (state == S_DRAW);
  assign bus.o_busy       = (state != S_IDLE);
  assign bus.o_X0         = x0_q;
  assign bus.o_Y0         = y0_q;
  assign bus.o_X1         = x1_q;
  assign bus.o_Y1         = y1_q;
  assign bus.o_colour     = colour_q;
  assign bus.o_full       = (count == FULL_CNT);
  assign bus.o_empty      = (count == '0);
  assign bus.o_count      = count;
  assign bus.o_lines_done = lines_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.dbg_state    = state;
endmodule
